// File: rtl/reu_pkg.sv
// Shared REU definitions: arbiter state encoding and window geometry defaults.
package reu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        OWN     = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam int WIN_LEN_DEF = 16;
    localparam int CYC_LEN_DEF = 32;
    localparam int CNT_W       = 5;

endpackage

// File: rtl/reu_dma_window.sv
// Window generator: turns an arm pulse into a WIN_LEN-clock dma_cycle window,
// starting WIN_OFS clocks after the arm, with an abort that kills it at once.
module reu_dma_window
    import reu_pkg::*;
#(
    parameter int WIN_OFS = 0,
    parameter int WIN_LEN = WIN_LEN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             abort,
    output logic             dma_cycle,
    output logic [CNT_W-1:0] win_cnt
);

    logic       pend;
    logic [5:0] ofs_cnt;

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            pend      <= 1'b0;
            ofs_cnt   <= '0;
            dma_cycle <= 1'b0;
            win_cnt   <= '0;
        end else if (arm) begin
            // a new arm always restarts, truncating any open window
            win_cnt <= '0;
            ofs_cnt <= 6'd1;
            if (WIN_OFS == 0) begin
                pend      <= 1'b0;
                dma_cycle <= 1'b1;
            end else begin
                pend      <= 1'b1;
                dma_cycle <= 1'b0;
            end
        end else if (pend) begin
            if (ofs_cnt == 6'(WIN_OFS)) begin
                pend      <= 1'b0;
                dma_cycle <= 1'b1;
                win_cnt   <= '0;
            end else begin
                ofs_cnt <= ofs_cnt + 6'd1;
            end
        end else if (dma_cycle) begin
            if (win_cnt == CNT_W'(WIN_LEN - 1)) begin
                dma_cycle <= 1'b0;
                win_cnt   <= '0;
            end else begin
                win_cnt <= win_cnt + 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_trunc: assert property (@(posedge clk) disable iff (reset)
        arm |-> !(pend || (dma_cycle && win_cnt != CNT_W'(WIN_LEN - 1))))
        else $error("dma window truncated by early cyc_start");
`endif

endmodule

// File: rtl/reu_dma_arb.sv
// REU bus-side DMA arbiter: halts the CPU via RDY, drains, then issues one
// dma_cycle window per non-stolen bus cycle until dma_req drops.
module reu_dma_arb
    import reu_pkg::*;
#(
    parameter int BA_DELAY = 3,
    parameter int WIN_OFS  = 0,
    parameter int WIN_LEN  = WIN_LEN_DEF,
    parameter int CYC_LEN  = CYC_LEN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cyc_start,
    input  logic             vic_ba,
    input  logic             dma_req,
    output logic             cpu_rdy,
    output logic             dma_busy,
    output logic             dma_cycle,
    output logic [CNT_W-1:0] win_cnt
);

    if (WIN_LEN < 1 || WIN_LEN > 32) begin : g_bad_len
        $error("WIN_LEN must be 1..32");
    end
    if (WIN_OFS < 0 || WIN_OFS + WIN_LEN > CYC_LEN || CYC_LEN > 63) begin : g_bad_cyc
        $error("window does not fit in CYC_LEN");
    end
    if (BA_DELAY < 0 || BA_DELAY > 15) begin : g_bad_ba
        $error("BA_DELAY must be 0..15");
    end

    arb_state_t state;
    logic [3:0] ba_cnt;
    logic       drain_done;
    logic       arm;
    logic       abort;

    assign drain_done = (state == DRAIN) && (ba_cnt == 4'(BA_DELAY));
    assign abort      = (state == OWN) && !dma_req;
    assign arm        = cyc_start && vic_ba && dma_req &&
                        ((state == OWN) || (state == RELEASE) || drain_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cpu_rdy  <= 1'b1;
            dma_busy <= 1'b0;
            ba_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dma_req) begin
                        cpu_rdy <= 1'b0;
                        ba_cnt  <= '0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!dma_req) begin
                        cpu_rdy <= 1'b1;
                        state   <= IDLE;
                    end else if (cyc_start) begin
                        if (drain_done) begin
                            dma_busy <= 1'b1;
                            state    <= OWN;
                        end else begin
                            ba_cnt <= ba_cnt + 4'd1;
                        end
                    end
                end
                OWN: begin
                    if (!dma_req) state <= RELEASE;
                end
                RELEASE: begin
                    // CPU is still halted, so a re-request skips the drain
                    if (dma_req) begin
                        state <= OWN;
                    end else if (cyc_start) begin
                        dma_busy <= 1'b0;
                        cpu_rdy  <= 1'b1;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

    reu_dma_window #(
        .WIN_OFS (WIN_OFS),
        .WIN_LEN (WIN_LEN)
    ) u_win (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .abort     (abort),
        .dma_cycle (dma_cycle),
        .win_cnt   (win_cnt)
    );

`ifndef SYNTHESIS
    a_own_only: assert property (@(posedge clk) disable iff (reset)
        dma_cycle |-> (dma_busy && !cpu_rdy))
        else $error("dma_cycle outside bus ownership");
`endif

endmodule
